// File: rtl/psum_acc_ctrl.sv
// ============================================================================
// Module   : psum_acc_ctrl
// Purpose  : Partial-sum accumulate/drain controller for a dual-port 128b x16
//            SRAM. Optional lane ReLU on drain output: PSUM_ACC_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_acc_ctrl #(
    parameter int LANES     = 8,
    parameter int NUM_WORDS = 16,
    localparam int DW = LANES * 16,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int LW = $clog2(NUM_WORDS + 1)
) (
    input  logic          CLK,
    input  logic          reset_n,
    // accumulate request channel
    input  logic          acc_valid,
    output logic          acc_ready,
    input  logic          acc_first,
    input  logic [AW-1:0] acc_addr,
    input  logic [DW-1:0] acc_data,
    // drain control and output channel
    input  logic          drain_start,
    input  logic [LW-1:0] drain_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    // status
    output logic          busy,
    output logic          done,
    // SRAM side
    output logic          sram_wen,
    output logic          sram_ren,
    output logic [AW-1:0] sram_w_A,
    output logic [AW-1:0] sram_r_A,
    output logic [DW-1:0] sram_D,
    input  logic [DW-1:0] sram_Q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_first_q, wb_first_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    logic          w_drain_prio;
    logic          w_acc_accept;
    logic          w_words_left;
    logic          w_out_free;
    logic          w_rd_issue;
    logic          w_drain_fin;
    logic [LW-1:0] w_len_clamped;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_post;

    // A drain request wins over a new beat only from IDLE with nothing in flight.
    assign w_drain_prio  = (state_q == S_IDLE) && !wb_valid_q && drain_start;
    assign acc_ready     = rdy_q && (state_q != S_DRAIN) && !w_drain_prio;
    assign w_acc_accept  = acc_valid && acc_ready;

    assign w_words_left  = (ptr_q < len_q);
    assign w_out_free    = !out_valid_q || out_ready;
    assign w_rd_issue    = (state_q == S_DRAIN) && !done_q && w_words_left && w_out_free;
    assign w_drain_fin   = (state_q == S_DRAIN) && !done_q && !w_words_left && w_out_free;
    assign w_len_clamped = (drain_len > LW'(NUM_WORDS)) ? LW'(NUM_WORDS) : drain_len;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (w_acc_accept) begin
                    state_d = S_ACC;
                end else if (w_drain_prio) begin
                    state_d = S_DRAIN;
                    ptr_d   = '0;
                    len_d   = w_len_clamped;
                end
            end
            S_ACC: begin
                // Any outstanding writeback retires on this same edge.
                if (!w_acc_accept) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_rd_issue) begin
                    ptr_d = ptr_q + LW'(1);
                end
                if (done_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy_d       = 1'b1;
        wb_valid_d  = w_acc_accept;
        wb_first_d  = w_acc_accept ? acc_first : wb_first_q;
        wb_addr_d   = w_acc_accept ? acc_addr  : wb_addr_q;
        wb_data_d   = w_acc_accept ? acc_data  : wb_data_q;
        out_valid_d = out_valid_q;
        if (w_rd_issue) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        done_d      = w_drain_fin;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_first_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            wb_valid_q  <= wb_valid_d;
            wb_first_q  <= wb_first_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [15:0] w_base;
            assign w_base                = wb_first_q ? 16'd0 : sram_Q[16*gi +: 16];
            assign w_sum[16*gi +: 16]    = w_base + wb_data_q[16*gi +: 16];
`ifdef PSUM_ACC_RELU_EN
            assign w_post[16*gi +: 16]   = sram_Q[16*gi+15] ? 16'd0 : sram_Q[16*gi +: 16];
`else
            assign w_post[16*gi +: 16]   = sram_Q[16*gi +: 16];
`endif
        end
    endgenerate

    assign sram_ren  = w_acc_accept || w_rd_issue;
    assign sram_r_A  = w_acc_accept ? acc_addr :
                       (w_rd_issue ? ptr_q[AW-1:0] : '0);
    assign sram_wen  = wb_valid_q;
    assign sram_w_A  = wb_valid_q ? wb_addr_q : '0;
    assign sram_D    = wb_valid_q ? w_sum : '0;

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? w_post : '0;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) || wb_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_acc_ctrl.sv
// Scoreboard bench for psum_acc_ctrl: SRAM model, write/drain queues,
// directed accumulate and drain vectors with hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_psum_acc_ctrl;

    localparam int LANES     = 8;
    localparam int NUM_WORDS = 16;
    localparam int DW        = LANES * 16;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          acc_valid = 1'b0;
    logic          acc_ready;
    logic          acc_first = 1'b0;
    logic [3:0]    acc_addr = '0;
    logic [DW-1:0] acc_data = '0;
    logic          drain_start = 1'b0;
    logic [4:0]    drain_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy, done;
    logic          sram_wen, sram_ren;
    logic [3:0]    sram_w_A, sram_r_A;
    logic [DW-1:0] sram_D, sram_Q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]    exp_wr_a[$];
    logic [DW-1:0] exp_wr_d[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] img[NUM_WORDS];

    always #5 CLK = ~CLK;

    psum_acc_ctrl #(.LANES(LANES), .NUM_WORDS(NUM_WORDS)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_first(acc_first),
        .acc_addr(acc_addr), .acc_data(acc_data),
        .drain_start(drain_start), .drain_len(drain_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done),
        .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_w_A(sram_w_A), .sram_r_A(sram_r_A),
        .sram_D(sram_D), .sram_Q(sram_Q)
    );

    // Dual-port SRAM: registered read address, combinational Q.
    logic [DW-1:0] mem[NUM_WORDS];
    logic [3:0]    raddr_q;
    always @(posedge CLK) begin
        if (sram_wen) mem[sram_w_A] <= sram_D;
        if (sram_ren) raddr_q <= sram_r_A;
    end
    assign sram_Q = mem[raddr_q];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] L(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [DW-1:0] post(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = w;
`ifdef PSUM_ACC_RELU_EN
        for (int i = 0; i < LANES; i++)
            if (w[16*i+15]) r[16*i +: 16] = 16'd0;
`endif
        return r;
    endfunction

    // Monitor: every writeback and every output handshake pops the scoreboard.
    always @(negedge CLK) begin
        logic [3:0]    ea;
        logic [DW-1:0] ed;
        if (sram_wen) begin
            if (exp_wr_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no write", sram_w_A, sram_D);
            end else begin
                ea = exp_wr_a.pop_front();
                ed = exp_wr_d.pop_front();
                chk("wr_addr", DW'(sram_w_A), DW'(ea));
                chk("wr_data", sram_D, ed);
            end
        end
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL out_unexpected: got %h expected no output", out_data);
            end else begin
                ed = exp_out.pop_front();
                chk("out_data", out_data, ed);
            end
        end
    end

    // One accept cycle; called at posedge+1 with the DUT able to take a beat.
    task automatic beat(input logic [3:0] a, input logic [DW-1:0] d, input logic f,
                        input logic [DW-1:0] exp, input bit push);
        acc_valid = 1'b1; acc_addr = a; acc_data = d; acc_first = f;
        if (push) begin
            exp_wr_a.push_back(a);
            exp_wr_d.push_back(exp);
            img[a] = exp;
        end
        @(negedge CLK);
        chk("acc_ready", DW'(acc_ready), DW'(1));
        chk("acc_ren", DW'(sram_ren), DW'(1));
        chk("acc_rA", DW'(sram_r_A), DW'(a));
        @(posedge CLK); #1;
        acc_valid = 1'b0; acc_first = 1'b0;
    endtask

    task automatic drain(input int len, input int lead, input logic [15:0] pat,
                         output logic [31:0] vmask, output int done_cyc);
        int n;
        int cyc;
        bit seen;
        n = (len > NUM_WORDS) ? NUM_WORDS : len;
        for (int i = 0; i < n; i++) exp_out.push_back(post(img[i]));
        drain_len = 5'(len);
        drain_start = 1'b1;
        for (int k = 0; k < lead; k++) begin
            @(negedge CLK);
            if (k == lead - 1) chk("drain_prio_ready", DW'(acc_ready), DW'(0));
            else               chk("wb_before_drain", DW'(sram_wen), DW'(1));
            @(posedge CLK); #1;
        end
        drain_start = 1'b0;
        vmask = '0; done_cyc = -1; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            out_ready = pat[cyc % 16];
            @(negedge CLK);
            if (cyc == 0) begin
                chk("entry_ren", DW'(sram_ren), DW'(n > 0));
                if (n > 0) chk("entry_rA", DW'(sram_r_A), DW'(0));
            end
            if (out_valid && !out_ready) chk("stall_data", out_data, exp_out[0]);
            if (out_valid && cyc < 32) vmask[cyc] = 1'b1;
            if (done) begin seen = 1'b1; done_cyc = cyc; end
            @(posedge CLK); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_done_seen", DW'(seen), DW'(1));
        chk("drain_all_words", DW'(exp_out.size()), DW'(0));
        @(negedge CLK);
        chk("done_one_cycle", DW'({done, busy}), DW'(0));
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] vm;
        int dc;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", DW'({acc_ready, out_valid, done, busy, sram_wen, sram_ren}), DW'(0));
        chk("rst_addr", DW'({sram_w_A, sram_r_A}), DW'(0));
        chk("rst_D", sram_D, '0);
        reset_n = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_rst", DW'(acc_ready), DW'(1));

        // Known contents in every word, 16 back-to-back first beats
        for (int i = 0; i < NUM_WORDS; i++) beat(4'(i), L(16'(i)), 1'b1, L(16'(i)), 1'b1);

        // Interleaved first/accumulate beats
        beat(4'd3, L(16'h0005), 1'b1, L(16'h0005), 1'b1);
        beat(4'd5, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1,
             128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1);
        beat(4'd3, L(16'h0002), 1'b0, L(16'h0007), 1'b1);
        beat(4'd5, L(16'h0010), 1'b0, 128'h0018_0017_0016_0015_0014_0013_0012_0011, 1'b1);
        // Same-address back-to-back, wrap without saturation
        beat(4'd7, L(16'h0001), 1'b1, L(16'h0001), 1'b1);
        beat(4'd7, L(16'h7FFF), 1'b0, L(16'h8000), 1'b1);
        beat(4'd8, L(16'hFFFF), 1'b1, L(16'hFFFF), 1'b1);
        beat(4'd8, 128'h0001_0002_0003_0004_0005_0006_0007_8001, 1'b0,
             128'h0000_0001_0002_0003_0004_0005_0006_8000, 1'b1);
        beat(4'd0, L(16'h0123), 1'b1, L(16'h0123), 1'b1);
        beat(4'd1, L(16'hFFF0), 1'b1, L(16'hFFF0), 1'b1);
        beat(4'd2, 128'h7FFF_FFF0_0001_8000_0002_0000_FFFF_0100, 1'b1,
             128'h7FFF_FFF0_0001_8000_0002_0000_FFFF_0100, 1'b1);
        @(posedge CLK); #1;

        // Reset with a writeback pending: the write is dropped
        beat(4'd4, L(16'h0555), 1'b1, '0, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_acc", DW'({sram_wen, busy, acc_ready}), DW'(0));
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        chk("ready_in_rst_release", DW'(acc_ready), DW'(0));
        @(posedge CLK); #1;
        chk("ready_after_rst2", DW'(acc_ready), DW'(1));

        drain(4, 1, 16'hFFFF, vm, dc);
        chk("len4_valid_cycles", DW'(vm), DW'(32'h1E));
        chk("len4_done_cycle", DW'(dc), DW'(5));

        drain(5, 1, 16'hFFF3, vm, dc);
        chk("toggle_valid_cycles", DW'(vm), DW'(32'hFE));
        chk("toggle_done_cycle", DW'(dc), DW'(8));

        drain(3, 1, 16'h5555, vm, dc);
        chk("alt_valid_cycles", DW'(vm), DW'(32'h7E));
        chk("alt_done_cycle", DW'(dc), DW'(7));

        drain(0, 1, 16'hFFFF, vm, dc);
        chk("len0_valid_cycles", DW'(vm), DW'(0));
        chk("len0_done_cycle", DW'(dc), DW'(1));

        drain(20, 1, 16'hFFFF, vm, dc);
        chk("clamp_valid_cycles", DW'(vm), DW'(32'h1FFFE));
        chk("clamp_done_cycle", DW'(dc), DW'(17));

        // drain_start while a beat is in writeback
        beat(4'd9, L(16'h0010), 1'b1, L(16'h0010), 1'b1);
        beat(4'd9, L(16'h0020), 1'b0, L(16'h0030), 1'b1);
        drain(10, 2, 16'hFFFF, vm, dc);
        chk("late_valid_cycles", DW'(vm), DW'(32'h7FE));
        chk("late_done_cycle", DW'(dc), DW'(11));

        // Reset in the middle of a drain
        for (int i = 0; i < 8; i++) exp_out.push_back(post(img[i]));
        drain_len = 5'd8; drain_start = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1;
        drain_start = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        #1 reset_n = 1'b0;
        #1;
        chk("rst_drain_ctrl", DW'({acc_ready, out_valid, done, busy, sram_wen, sram_ren}), DW'(0));
        chk("rst_drain_addr", DW'({sram_w_A, sram_r_A}), DW'(0));
        chk("rst_drain_D", sram_D, '0);
        chk("rst_drain_out", out_data, '0);
        exp_out.delete();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("no_done_in_rst", DW'(done), DW'(0));
        end
        reset_n = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_rst3", DW'(acc_ready), DW'(1));
        drain(2, 1, 16'hFFFF, vm, dc);
        chk("fresh_valid_cycles", DW'(vm), DW'(32'h6));
        chk("fresh_done_cycle", DW'(dc), DW'(3));

        chk("wr_queue_empty", DW'(exp_wr_a.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/psum_acc_ctrl.md
PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 8: 16-bit partial-sum lanes per SRAM word (128b word).
REQ-002 SHALL have parameter NUM_WORDS, default 16: SRAM depth; addresses are 4 bits.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports acc_valid in 1, acc_ready out 1, acc_first in 1 (overwrite, do not add), acc_addr in 4, acc_data in 128: the accumulate request channel.
REQ-006 SHALL have ports drain_start in 1 (level request), drain_len in 5 (word count 0..16).
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_data out 128: the drain output channel.
REQ-008 SHALL have ports busy out 1 (state != IDLE or writeback pending) and done out 1 (one-cycle pulse).
REQ-009 SHALL have SRAM-side ports sram_wen out 1, sram_ren out 1, sram_w_A out 4, sram_r_A out 4, sram_D out 128, sram_Q in 128. The SRAM is a dual-port 128b x16: write on posedge, read address registered on posedge, Q combinational from the registered address.

Function
REQ-010 SHALL implement states IDLE, ACC, DRAIN. IDLE->ACC on an accepted acc beat. ACC->IDLE when no beat is accepted and no writeback is pending. IDLE->DRAIN when drain_start=1, no writeback is pending, and no acc beat is accepted that cycle. DRAIN->IDLE after done.
REQ-011 acc_ready SHALL be 1 in IDLE and ACC and 0 in DRAIN. drain_start SHALL take priority over acc_valid only in IDLE with the pipeline empty.
REQ-012 On an accepted beat in cycle t: sram_ren=1 and sram_r_A=acc_addr. acc_addr, acc_data and acc_first SHALL be registered into the writeback stage.
REQ-013 In cycle t+1: sram_wen=1, sram_w_A=registered addr, sram_D[16i+15:16i]=base_i+data_i mod 2^16 per lane. base_i=0 if first, else sram_Q lane i.
REQ-014 Throughput SHALL be one beat per cycle; back-to-back beats to the same address SHALL need no forwarding or stall, because the write and the read-address capture share an edge.
REQ-015 In DRAIN, the read pointer SHALL start at 0 and drain_len SHALL be latched; values >16 are clamped to 16.
REQ-016 A read SHALL be issued (sram_ren=1, sram_r_A=ptr) when words remain AND (out_valid=0 OR out_ready=1). The pointer increments on issue. out_valid SHALL be 1 in the cycle after an issue.
REQ-017 out_data SHALL equal sram_Q (post-processed per REQ-024). While out_valid=1 and out_ready=0, sram_ren=0 so out_data holds stable.
REQ-018 Drain throughput SHALL be 1 word/cycle with out_ready held high.
REQ-019 done SHALL pulse in the cycle after the last handshake; for drain_len=0, done SHALL pulse in the cycle after DRAIN entry with no reads issued.
REQ-020 sram_wen SHALL be 0 throughout DRAIN, and sram_wen/sram_ren SHALL both be 0 in IDLE.

Reset
REQ-021 On reset_n=0, immediately: state=IDLE; acc_ready=0 during reset; out_valid, done, busy, sram_wen, sram_ren=0; sram_w_A, sram_r_A, sram_D=0; pointers and counters cleared.
REQ-022 A reset mid-ACC SHALL drop any pending writeback. A reset mid-DRAIN SHALL abort without done. SRAM contents are not cleared.
REQ-023 After reset_n rises, acc_ready SHALL be 1 from the first clock edge.

Configuration
REQ-024 With macro PSUM_ACC_RELU_EN defined, each out_data lane SHALL be max(signed lane, 0). Without it, out_data=sram_Q unmodified. Accumulation SHALL be unaffected either way.

Verification
REQ-025 Scenario: first beat to addr 3 with all lanes 0x0005, then a non-first beat to addr 3 with all lanes 0x0002 on consecutive cycles -> the second writeback has D lanes 0x0007.
REQ-026 Scenario: non-first beat with lane 0x7FFF onto stored 0x0001 -> written lane 0x8000 (wrap, no saturation).
REQ-027 Scenario: drain_len=4 with out_ready=1 -> out_valid high 4 consecutive cycles, addrs 0..3 in order, done pulse on the next cycle.
REQ-028 Scenario: drain with out_ready toggling 1,0,0,1 -> out_data stable while stalled, no word skipped or duplicated; drain_len=0 -> done only.
REQ-029 Scenario: drain_start asserted while an acc beat is in writeback -> DRAIN entered one cycle later; the drained word reflects the final sum.
REQ-030 Scenario: reset_n low mid-DRAIN -> all outputs 0 immediately; no done; a fresh drain afterwards starts at addr 0; with PSUM_ACC_RELU_EN a stored lane 0xFFF0 drains as 0x0000.
